// File: rtl/ct_pkg.sv
// Shared definitions for the cut-through path: arbiter state encoding and
// the ceiling-log2 helper used to size index fields.
package ct_pkg;

  typedef enum logic [0:0] {
    CT_ARB_IDLE   = 1'b0,
    CT_ARB_LOCKED = 1'b1
  } ct_arb_state_e;

  function automatic int unsigned ct_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ct_rr_arb_if.sv
// Requester-side and downstream-side beat signals of the round-robin arbiter.
interface ct_rr_arb_if
  import ct_pkg::*;
#(
  parameter int unsigned NI    = 4,
  parameter int unsigned WIDTH = 256
);
  localparam int unsigned GW = ct_clog2(NI);

  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       o_ready;
  logic [WIDTH-1:0]    o_data;
  logic                o_valid;
  logic                o_eop;
  logic [GW-1:0]       o_grant;
  logic                i_ready;

  modport master (
    input  i_data, i_valid, i_eop, i_ready,
    output o_ready, o_data, o_valid, o_eop, o_grant
  );

  modport slave (
    output i_data, i_valid, i_eop, i_ready,
    input  o_ready, o_data, o_valid, o_eop, o_grant
  );

endinterface

// File: rtl/ct_rr_pick.sv
// Combinational cyclic priority search: first set bit of req starting at ptr.
module ct_rr_pick
  import ct_pkg::*;
#(
  parameter int unsigned NI = 4
) (
  input  logic [NI-1:0]            req,
  input  logic [ct_clog2(NI)-1:0]  ptr,
  output logic                     any,
  output logic [ct_clog2(NI)-1:0]  idx
);
  localparam int unsigned GW = ct_clog2(NI);

  always_comb begin
    logic [GW:0]   s;
    logic [GW-1:0] p;
    any = 1'b0;
    idx = ptr;
    s   = '0;
    p   = '0;
    for (int unsigned j = 0; j < NI; j++) begin
      // one extra bit so ptr+j cannot overflow before the mod-NI wrap
      s = {1'b0, ptr} + (GW+1)'(j);
      if (s >= (GW+1)'(NI)) s = s - (GW+1)'(NI);
      p = s[GW-1:0];
      if (!any && req[p]) begin
        any = 1'b1;
        idx = p;
      end
    end
  end

endmodule

// File: rtl/ct_rr_arb.sv
// Packet-level round-robin arbiter: locks onto a requester until its eop beat,
// then rotates priority; single output register stage with backpressure.
module ct_rr_arb
  import ct_pkg::*;
#(
  parameter int unsigned NI    = 4,
  parameter int unsigned WIDTH = 256
) (
  input logic         clk,
  input logic         reset,
  ct_rr_arb_if.master bus
);
  localparam int unsigned GW = ct_clog2(NI);

  ct_arb_state_e  state, state_nxt;
  logic [GW-1:0]  ptr, ptr_nxt;
  logic [GW-1:0]  gnt, gnt_nxt;
  logic           pick_any;
  logic [GW-1:0]  pick_idx;
  logic [NI-1:0]  first_mask;
  logic [NI-1:0]  ready;
  logic           load_en;
  logic           fire;
  logic           fire_eop;
  logic [GW-1:0]  fire_idx;
  logic [WIDTH-1:0] fire_data;

  function automatic logic [GW-1:0] idx_inc(input logic [GW-1:0] x);
    return (x == GW'(NI - 1)) ? '0 : x + GW'(1);
  endfunction

  ct_rr_pick #(.NI(NI)) u_pick (
    .req (bus.i_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign load_en = !bus.o_valid || bus.i_ready;

  // Ready for k in IDLE means "no valid requester ahead of k in the rotation";
  // it never looks at i_valid[k], and only the winner can be both valid and ready.
  always_comb begin
    logic          blocked;
    logic [GW:0]   s;
    logic [GW-1:0] p;
    first_mask = '0;
    blocked    = 1'b0;
    s          = '0;
    p          = '0;
    for (int unsigned j = 0; j < NI; j++) begin
      s = {1'b0, ptr} + (GW+1)'(j);
      if (s >= (GW+1)'(NI)) s = s - (GW+1)'(NI);
      p = s[GW-1:0];
      first_mask[p] = !blocked;
      blocked       = blocked | bus.i_valid[p];
    end
  end

  // Next-state, ready and transfer decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    ready     = '0;
    fire_idx  = gnt;
    fire      = 1'b0;
    fire_eop  = 1'b0;
    unique case (state)
      CT_ARB_IDLE: begin
        fire_idx = pick_idx;
        if (load_en) ready = first_mask;
      end
      CT_ARB_LOCKED: begin
        fire_idx   = gnt;
        ready[gnt] = load_en;
      end
      default: ;
    endcase
    if (reset) ready = '0;
    fire     = |(ready & bus.i_valid);
    fire_eop = bus.i_eop[fire_idx];
    if (fire) begin
      if (state == CT_ARB_IDLE) begin
        if (fire_eop) begin
          ptr_nxt = idx_inc(fire_idx);
        end else begin
          state_nxt = CT_ARB_LOCKED;
          gnt_nxt   = fire_idx;
        end
      end else if (fire_eop) begin
        state_nxt = CT_ARB_IDLE;
        ptr_nxt   = idx_inc(gnt);
      end
    end
  end

  assign bus.o_ready = ready;

  always_comb begin
    fire_data = '0;
    for (int unsigned k = 0; k < NI; k++) begin
      if (fire_idx == GW'(k)) fire_data = bus.i_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CT_ARB_IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Output register: refills whenever empty or being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.o_valid <= 1'b0;
      bus.o_eop   <= 1'b0;
      bus.o_grant <= '0;
    end else if (load_en) begin
      bus.o_valid <= fire;
      if (fire) begin
        bus.o_eop   <= fire_eop;
        bus.o_grant <= fire_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && fire) bus.o_data <= fire_data;
  end

endmodule

// File: tb/tb_ct_rr_arb.sv
// Directed bench for ct_rr_arb with an in-order beat scoreboard.
module tb_ct_rr_arb;
  import ct_pkg::*;

  localparam int unsigned NI    = 4;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ct_rr_arb_if #(.NI(NI), .WIDTH(WIDTH)) bus ();

  ct_rr_arb #(.NI(NI), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [NI-1:0] src_en;
  int            src_len  [NI];
  int            src_seq  [NI];
  int            src_beat [NI];
  logic          rdy;
  logic          rst_v;

  typedef struct packed {
    logic [1:0]       k;
    logic [WIDTH-1:0] d;
    logic             e;
  } beat_t;

  beat_t      q[$];
  logic       last_open = 1'b0;
  logic [1:0] last_g    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] dat(input int k, input int seq);
    return {8'(k), 24'(seq)};
  endfunction

  // One cycle: drive at negedge, then advance sources that were accepted.
  task automatic cyc();
    @(negedge clk);
    reset       = rst_v;
    bus.i_ready = rdy;
    for (int k = 0; k < NI; k++) begin
      bus.i_valid[k]                = src_en[k];
      bus.i_data[k*WIDTH +: WIDTH]  = dat(k, src_seq[k]);
      bus.i_eop[k]                  = (src_beat[k] == src_len[k] - 1);
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      if (bus.i_valid[k] && bus.o_ready[k]) begin
        src_seq[k]++;
        src_beat[k] = (src_beat[k] == src_len[k] - 1) ? 0 : src_beat[k] + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_v  = 1'b1;
    src_en = '0;
    for (int k = 0; k < NI; k++) begin
      src_seq[k]  = 0;
      src_beat[k] = 0;
      src_len[k]  = 2;
    end
    cyc();
    cyc();
    rst_v = 1'b0;
  endtask

  // Every accepted beat must leave exactly once, in acceptance order, unbroken per packet.
  always @(posedge clk) begin
    beat_t b;
    if (reset) begin
      q.delete();
      last_open = 1'b0;
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          b = q.pop_front();
          chk("sb_beat", 64'({bus.o_grant, bus.o_data, bus.o_eop}), 64'(b));
        end
        if (last_open) chk("sb_interleave", 64'(bus.o_grant), 64'(last_g));
        last_open = !bus.o_eop;
        last_g    = bus.o_grant;
      end
      for (int k = 0; k < NI; k++) begin
        if (bus.i_valid[k] && bus.o_ready[k])
          q.push_back({2'(k), bus.i_data[k*WIDTH +: WIDTH], bus.i_eop[k]});
      end
    end
  end

  initial begin
    reset       = 1'b1;
    bus.i_valid = '0;
    bus.i_eop   = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    rdy         = 1'b1;
    rst_v       = 1'b1;
    src_en      = 4'b1111;
    for (int k = 0; k < NI; k++) begin
      src_len[k]  = 2;
      src_seq[k]  = 0;
      src_beat[k] = 0;
    end

    // reset state, o_ready forced low while reset is high
    cyc();
    cyc();
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_eop",   64'(bus.o_eop),   64'd0);
    chk("rst_grant", 64'(bus.o_grant), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);

    // all four streaming 2-beat packets: 0,0,1,1,2,2,3,3,0,0
    rst_v = 1'b0;
    cyc();
    chk("a_ready0", 64'(bus.o_ready), 64'b0001);
    chk("a_nolat",  64'(bus.o_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("a_valid%0d", i), 64'(bus.o_valid), 64'd1);
      chk($sformatf("a_grant%0d", i), 64'(bus.o_grant), 64'((i / 2) % 4));
      chk($sformatf("a_eop%0d", i),   64'(bus.o_eop),   64'(i % 2));
      if (i == 2) chk("a_data2", 64'(bus.o_data), 64'(dat(1, 0)));
    end

    // 3-beat packet from req2; req0/req3 arrive mid-packet and must wait
    do_reset();
    src_len[2] = 3;
    src_en     = 4'b0100;
    cyc();
    chk("b_win2", 64'(bus.o_ready & bus.i_valid), 64'b0100);
    src_en = 4'b1101;
    cyc();
    chk("b_hold_c2", 64'(bus.o_ready), 64'b0100);
    cyc();
    chk("b_hold_c3", 64'(bus.o_ready), 64'b0100);
    cyc();
    chk("b_next3",   64'(bus.o_ready & bus.i_valid), 64'b1000);
    chk("b_eopout",  64'(bus.o_eop),   64'd1);
    chk("b_eopgnt",  64'(bus.o_grant), 64'd2);
    cyc();
    chk("b_gnt3",    64'(bus.o_grant), 64'd3);
    cyc();
    chk("b_win0",    64'(bus.o_ready & bus.i_valid), 64'b0001);
    cyc();
    chk("b_gnt0",    64'(bus.o_grant), 64'd0);

    // downstream stall for 5 cycles mid-packet
    do_reset();
    src_len[1] = 8;
    src_en     = 4'b0010;
    cyc();
    cyc();
    cyc();
    chk("c_pre", 64'(bus.o_data), 64'(dat(1, 1)));
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("c_valid%0d", i), 64'(bus.o_valid), 64'd1);
      chk($sformatf("c_data%0d", i),  64'(bus.o_data),  64'(dat(1, 2)));
      chk($sformatf("c_ready%0d", i), 64'(bus.o_ready), 64'd0);
    end
    rdy = 1'b1;
    cyc();
    chk("c_resume_rdy",  64'(bus.o_ready), 64'b0010);
    chk("c_resume_data", 64'(bus.o_data),  64'(dat(1, 2)));
    cyc();
    chk("c_next_data",   64'(bus.o_data),  64'(dat(1, 3)));

    // req1 goes idle inside a packet while req3 waits
    do_reset();
    src_len[1] = 6;
    src_en     = 4'b0010;
    cyc();
    cyc();
    src_en = 4'b1000;
    cyc();
    chk("d_lock_rdy", 64'(bus.o_ready), 64'b0010);
    chk("d_gnt1",     64'(bus.o_grant), 64'd1);
    cyc();
    chk("d_bubble1",  64'(bus.o_valid), 64'd0);
    chk("d_lock_rdy2", 64'(bus.o_ready), 64'b0010);
    cyc();
    chk("d_bubble2",  64'(bus.o_valid), 64'd0);
    src_en = 4'b1010;
    cyc();
    chk("d_bubble3",  64'(bus.o_valid), 64'd0);
    chk("d_lock_rdy3", 64'(bus.o_ready), 64'b0010);
    cyc();
    chk("d_resume",   64'(bus.o_data), 64'(dat(1, 2)));
    cyc();
    chk("d_no_r3",    64'(bus.o_ready), 64'b0010);
    cyc();
    cyc();
    chk("d_win3",     64'(bus.o_ready & bus.i_valid), 64'b1000);
    chk("d_lasteop",  64'(bus.o_eop),   64'd1);
    chk("d_lastgnt",  64'(bus.o_grant), 64'd1);
    cyc();
    chk("d_gnt3",     64'(bus.o_grant), 64'd3);

    // reset during beat 2 of a 4-beat packet from req3
    do_reset();
    src_len[3] = 4;
    src_en     = 4'b1000;
    cyc();
    chk("e_win3", 64'(bus.o_ready & bus.i_valid), 64'b1000);
    cyc();
    rst_v  = 1'b1;
    src_en = 4'b1110;
    cyc();
    chk("e_rst_ready", 64'(bus.o_ready), 64'd0);
    rst_v = 1'b0;
    cyc();
    chk("e_valid0", 64'(bus.o_valid), 64'd0);
    chk("e_win1",   64'(bus.o_ready & bus.i_valid), 64'b0010);
    cyc();
    chk("e_gnt1",   64'(bus.o_grant), 64'd1);
    chk("e_valid1", 64'(bus.o_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
